// File: rtl/mult_iter_unit.sv
// mult_iter_unit: iterative signed/unsigned multiplier, BITS_PER_CYCLE bits per cycle.
// Define MULT_ACC_EN to add the acc_op/acc_hi/acc_lo accumulate ports (MADD/MSUB).
module mult_iter_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sign,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
`ifdef MULT_ACC_EN
   input  logic [1:0]       acc_op,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int BPC  = BITS_PER_CYCLE;
   localparam int ITER = WIDTH / BPC;
   localparam int CW   = $clog2(ITER + 1);
   localparam int PW   = 2 * WIDTH;
   localparam int SW   = $clog2(PW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic             accept;
   logic             step;
   logic             finish;
   logic             retire;
   logic             last;

   logic [WIDTH-1:0] mag_a_q;
   logic [WIDTH-1:0] mag_b_q;
   logic             neg_q;
   logic [PW-1:0]    prod_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH+BPC-1:0] ppart;
   logic [SW-1:0]        shamt;
   logic [PW-1:0]        pp_ext;
   logic [PW-1:0]        prod_fix;
   logic [PW-1:0]        result;

`ifdef MULT_ACC_EN
   logic [1:0]       acc_op_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
`endif

   assign last = (cnt_q == CW'(ITER - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (last) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      accept   = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      retire   = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = !flush;
            accept   = !flush && in_valid;
         end
         BUSY: step   = !flush;
         FIX:  finish = !flush;
         DONE: retire = !flush && out_ready;
         default: ;
      endcase
   end

   // Magnitudes are WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1).
   assign abs_a = (sign && srca[WIDTH-1]) ? -srca : srca;
   assign abs_b = (sign && srcb[WIDTH-1]) ? -srcb : srcb;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_q   <= 1'b0;
      end else if (accept) begin
         mag_a_q <= abs_a;
         mag_b_q <= abs_b;
         neg_q   <= sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      end else if (step) begin
         mag_b_q <= mag_b_q >> BPC;
      end
   end

`ifdef MULT_ACC_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_op_q <= 2'b00;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
      end else if (accept) begin
         acc_op_q <= acc_op;
         acc_hi_q <= acc_hi;
         acc_lo_q <= acc_lo;
      end
   end
`endif

   assign ppart  = {{BPC{1'b0}}, mag_a_q}
                 * {{WIDTH{1'b0}}, mag_b_q[BPC-1:0]};
   assign shamt  = SW'(cnt_q) * SW'(BPC);
   assign pp_ext = PW'(ppart) << shamt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prod_q <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         prod_q <= '0;
         cnt_q  <= '0;
      end else if (step) begin
         prod_q <= prod_q + pp_ext;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   assign prod_fix = neg_q ? -prod_q : prod_q;

`ifdef MULT_ACC_EN
   always_comb begin
      result = prod_fix;
      unique case (acc_op_q)
         2'b01:   result = {acc_hi_q, acc_lo_q} + prod_fix;
         2'b10:   result = {acc_hi_q, acc_lo_q} - prod_fix;
         default: result = prod_fix;
      endcase
   end
`else
   assign result = prod_fix;
`endif

   // A flush in FIX drops the result; hi/lo keep the previous one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (finish) begin
         hi <= result[PW-1:WIDTH];
         lo <= result[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (finish) begin
         out_valid <= 1'b1;
      end else if (retire) begin
         out_valid <= 1'b0;
      end
   end

endmodule
